// File: rtl/pwm_capture.sv
// PWM input capture: synchronizes an external PWM pin and measures period and
// high time in clk cycles. It also derives a truncated duty percentage, counts
// completed measurements and raises a sticky interrupt on each measurement or
// on a stuck input.
module pwm_capture #(
  parameter int unsigned      CNT_W       = 16,
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = {CNT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pwm_in,
  input  logic             irq_clr,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] on_time_out,
  output logic [7:0]       duty_percent,
  output logic             meas_valid,
  output logic [7:0]       cycle_count,
  output logic             timeout,
  output logic             irq
);

  typedef enum logic [1:0] {StIdle, StArm, StHigh, StLow} state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] on_time_q, on_time_d;
  logic [7:0]       duty_q, duty_d;
  logic             meas_valid_q, meas_valid_d;
  logic [7:0]       cycle_count_q, cycle_count_d;
  logic             timeout_q, timeout_d;
  logic             irq_q, irq_d;
  logic             rise, fall, cap, tmo;
  logic [CNT_W+6:0] duty_prod;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  // hi_cnt * 100, evaluated against cnt (the period being captured) on cap
  assign duty_prod = {7'd0, hi_cnt_q} * {{CNT_W{1'b0}}, 7'd100};

  // Two-flop synchronizer plus history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Next-state: FSM, cycle counter, capture registers and status
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_cnt_d      = hi_cnt_q;
    period_d      = period_q;
    on_time_d     = on_time_q;
    duty_d        = duty_q;
    meas_valid_d  = 1'b0;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    cap           = 1'b0;
    tmo           = 1'b0;

    if (!enable) begin
      state_d   = StIdle;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d   = '0;
          state_d = StArm;
        end
        StArm: begin
          if (rise) begin
            cnt_d   = CntOne;
            state_d = StHigh;
          end else if (cnt_q == TIMEOUT_CYC) begin
            tmo = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StHigh: begin
          // Timeout checked first so cnt can never wrap past TIMEOUT_CYC
          if (cnt_q == TIMEOUT_CYC) begin
            tmo = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
            if (fall) begin
              hi_cnt_d = cnt_q;
              state_d  = StLow;
            end
          end
        end
        StLow: begin
          if (rise) begin
            cap = 1'b1;
          end else if (cnt_q == TIMEOUT_CYC) begin
            tmo = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (cap) begin
      period_d      = cnt_q;
      on_time_d     = hi_cnt_q;
      duty_d        = 8'(duty_prod / {7'd0, cnt_q});
      meas_valid_d  = 1'b1;
      cycle_count_d = cycle_count_q + 8'd1;
      timeout_d     = 1'b0;
      cnt_d         = CntOne;
      state_d       = StHigh;
    end

    if (tmo) begin
      timeout_d = 1'b1;
      duty_d    = s2_q ? 8'd100 : 8'd0;
      cnt_d     = '0;
      state_d   = StArm;
    end

    // Set covers the capture edge and the visible meas_valid cycle, so a
    // clear coinciding with meas_valid cannot drop the interrupt.
    if (meas_valid_d || meas_valid_q || (tmo && !timeout_q)) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      hi_cnt_q      <= '0;
      period_q      <= '0;
      on_time_q     <= '0;
      duty_q        <= '0;
      meas_valid_q  <= 1'b0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_cnt_q      <= hi_cnt_d;
      period_q      <= period_d;
      on_time_q     <= on_time_d;
      duty_q        <= duty_d;
      meas_valid_q  <= meas_valid_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      irq_q         <= irq_d;
    end
  end

  assign period_out   = period_q;
  assign on_time_out  = on_time_q;
  assign duty_percent = duty_q;
  assign meas_valid   = meas_valid_q;
  assign cycle_count  = cycle_count_q;
  assign timeout      = timeout_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a single-threaded clock stepper drives the
// PWM pin from a programmable high/low pattern while each task checks results.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_n, enable, pwm_in, irq_clr;
  logic [15:0] period_out, on_time_out;
  logic [7:0]  duty_percent, cycle_count;
  logic        meas_valid, timeout, irq;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_cc = 8'd0;

  // PWM pattern generator state
  bit          gen_on = 1'b0;
  int          gen_hi, gen_lo, cur_hi, cur_lo, ph;

  pwm_capture #(
    .CNT_W      (16),
    .TIMEOUT_CYC(16'd200)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .pwm_in      (pwm_in),
    .irq_clr     (irq_clr),
    .period_out  (period_out),
    .on_time_out (on_time_out),
    .duty_percent(duty_percent),
    .meas_valid  (meas_valid),
    .cycle_count (cycle_count),
    .timeout     (timeout),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // Advance one clock; pattern changes take effect at the next period start
  task automatic tick();
    @(posedge clk);
    #1;
    if (gen_on) begin
      if (ph >= cur_hi + cur_lo) begin
        ph = 0;
        cur_hi = gen_hi;
        cur_lo = gen_lo;
      end
      pwm_in = (ph < cur_hi);
      ph++;
    end
  endtask

  task automatic gen_start(input int hi, input int lo);
    gen_hi = hi; gen_lo = lo; cur_hi = hi; cur_lo = lo; ph = 0; gen_on = 1'b1;
  endtask

  task automatic wait_mv(input int limit, output int n);
    bit got = 1'b0;
    n = 0;
    while (!got && n < limit) begin
      tick();
      n++;
      if (meas_valid) got = 1'b1;
    end
    if (got) exp_cc = exp_cc + 8'd1;
    checks++;
    if (!got) begin errors++; $display("FAIL wait_mv no meas_valid within %0d cycles", limit); end
  endtask

  task automatic chk_meas(input string nm, input int p, input int o, input int d);
    checks++;
    if (period_out !== 16'(p)) begin errors++; $display("FAIL %s period got %0d exp %0d", nm, period_out, p); end
    checks++;
    if (on_time_out !== 16'(o)) begin errors++; $display("FAIL %s on_time got %0d exp %0d", nm, on_time_out, o); end
    checks++;
    if (duty_percent !== 8'(d)) begin errors++; $display("FAIL %s duty got %0d exp %0d", nm, duty_percent, d); end
    checks++;
    if (cycle_count !== exp_cc) begin errors++; $display("FAIL %s cycle_count got %0d exp %0d", nm, cycle_count, exp_cc); end
  endtask

  task automatic chk_all_zero(input string nm);
    checks++;
    if ({period_out, on_time_out, duty_percent, meas_valid, cycle_count, timeout, irq} !== '0) begin
      errors++;
      $display("FAIL %s outputs got p=%0d o=%0d d=%0d mv=%0b cc=%0d to=%0b irq=%0b exp all 0", nm,
               period_out, on_time_out, duty_percent, meas_valid, cycle_count, timeout, irq);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; pwm_in = 1'b0; irq_clr = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int n;
    enable = 1'b1;
    repeat (4) tick();
    gen_start(30, 70);
    wait_mv(300, n);
    checks++;
    if (n != 104) begin errors++; $display("FAIL basic first_latency got %0d exp 104", n); end
    chk_meas("basic", 100, 30, 30);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL basic irq got %0b exp 1", irq); end
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL basic timeout got %0b exp 0", timeout); end
    tick();
    checks++;
    if (meas_valid !== 1'b0) begin errors++; $display("FAIL basic pulse_width got %0b exp 0", meas_valid); end
    wait_mv(300, n);
    checks++;
    if (n != 99) begin errors++; $display("FAIL basic spacing got %0d exp 99", n); end
    chk_meas("basic2", 100, 30, 30);
  endtask

  task automatic test_pattern_change();
    int n;
    gen_hi = 4; gen_lo = 36;
    wait_mv(300, n);
    chk_meas("chg_old", 100, 30, 30);
    wait_mv(300, n);
    chk_meas("chg_4_36", 40, 4, 10);
    gen_hi = 90; gen_lo = 30;
    wait_mv(300, n);
    chk_meas("chg_trans", 40, 4, 10);
    wait_mv(300, n);
    chk_meas("chg_90_30", 120, 90, 75);
  endtask

  // Entered right after a meas_valid; also exercises set-wins-over-clear
  task automatic test_timeout_irq();
    int n;
    gen_on = 1'b0;
    pwm_in = 1'b1;
    irq_clr = 1'b1;
    tick();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins got %0b exp 1", irq); end
    tick();
    irq_clr = 1'b0;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %0b exp 0", irq); end
    repeat (197) tick();
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_early got %0b exp 0", timeout); end
    tick();
    checks++;
    if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_at_200 got %0b exp 1", timeout); end
    chk_meas("tmo_hold", 120, 90, 100);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL tmo_irq got %0b exp 1", irq); end
    checks++;
    if (meas_valid !== 1'b0) begin errors++; $display("FAIL tmo_no_mv got %0b exp 0", meas_valid); end
    gen_start(30, 70);
    wait_mv(400, n);
    chk_meas("tmo_restart", 100, 30, 30);
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_cleared got %0b exp 0", timeout); end
  endtask

  task automatic test_wrap();
    int n;
    gen_hi = 2; gen_lo = 2;
    for (int i = 0; i < 300 && exp_cc != 8'hFF; i++) wait_mv(300, n);
    wait_mv(300, n);
    checks++;
    if (cycle_count !== 8'd0) begin errors++; $display("FAIL wrap cycle_count got %0d exp 0", cycle_count); end
    chk_meas("wrap", 4, 2, 50);
  endtask

  task automatic test_enable_drop();
    int n;
    bit seen_mv = 1'b0;
    gen_hi = 30; gen_lo = 70;
    wait_mv(300, n);
    wait_mv(300, n);
    chk_meas("pre_drop", 100, 30, 30);
    repeat (5) tick();
    enable = 1'b0;
    repeat (250) begin
      tick();
      if (meas_valid) seen_mv = 1'b1;
    end
    checks++;
    if (seen_mv) begin errors++; $display("FAIL drop_no_mv got 1 exp 0"); end
    chk_meas("drop_hold", 100, 30, 30);
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL drop_timeout got %0b exp 0", timeout); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL drop_irq_hold got %0b exp 1", irq); end
    enable = 1'b1;
    wait_mv(400, n);
    chk_meas("reenable", 100, 30, 30);
  endtask

  task automatic test_reset_mid();
    int n;
    repeat (40) tick();
    rst_n = 1'b0;
    #2;
    chk_all_zero("reset_mid");
    repeat (2) tick();
    rst_n = 1'b1;
    exp_cc = 8'd0;
    wait_mv(400, n);
    checks++;
    if (n <= 100) begin errors++; $display("FAIL reset_fresh_cycle latency got %0d exp >100", n); end
    chk_meas("reset_after", 100, 30, 30);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pattern_change();
    test_timeout_irq();
    test_wrap();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
